// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter files.
//   UART_DATA_BITS   : data bits per frame (8).
//   uart_tx_state_t  : transmitter FSM state encoding.
//   uart_div()       : clock cycles per bit, clk_freq / baud with truncation.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO feeding the transmitter.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-low reset (flushes)
//   push, din    : write request and data; ignored while full
//   pop, dout    : read request and head-of-queue data; ignored while empty
//   full, empty  : occupancy flags from the registered count
//   count        : number of stored entries
// fifo_depth must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int  fifo_depth = 4,
  parameter int  width      = 8,
  localparam int PTR_W      = $clog2(fifo_depth),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [width-1:0] mem_q [fifo_depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(fifo_depth));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN).
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset; forces the line high, flushes FIFO
//   tx_data   : byte to send
//   tx_valid  : tx_data valid
//   tx_ready  : FIFO can accept a byte
//   uart_txd  : registered serial line, idles high, LSB first
//   tx_busy   : a frame is in progress or the FIFO holds bytes
// Handshake: a byte is taken on every rising edge where tx_valid && tx_ready;
// tx_ready depends only on the registered FIFO count, never on tx_valid.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after bit 7).
module uart_tx
  import uart_pkg::*;
#(
  parameter int clk_freq       = 50_000_000,
  parameter int uart_baud_rate = 115200,
  parameter int fifo_depth     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       tx_busy
);

  localparam int DIV    = uart_div(clk_freq, uart_baud_rate);
  localparam int BAUD_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam int CNT_W  = $clog2(fifo_depth) + 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx: clk_freq / uart_baud_rate must be at least 2");
  end
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_depth_check
    $error("uart_tx: fifo_depth must be a power of two and at least 2");
  end

  uart_tx_state_t      state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                baud_wrap;
  logic                fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [7:0]          fifo_dout;
  logic [CNT_W-1:0]    fifo_count;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign fifo_push = tx_valid && tx_ready;
  assign tx_ready  = !fifo_full;
  assign uart_txd  = txd_q;
  assign tx_busy   = (state_q != ST_IDLE) || (fifo_count != '0);
  assign baud_wrap = (baud_q == BAUD_W'(DIV - 1));

  uart_tx_fifo #(
    .fifo_depth (fifo_depth),
    .width      (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    // Outside IDLE the baud counter free-runs and wraps each bit period.
    baud_d   = baud_wrap ? '0 : baud_q + BAUD_W'(1);
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bit_d    = '0;
          state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_dout;
`endif
        end
      end
      ST_START: begin
        if (baud_wrap) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_wrap) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // A waiting byte chains straight into its start bit (no idle bit).
        if (baud_wrap) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            bit_d    = '0;
            state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_dout;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase

    // Line value follows the current state; registering it one cycle later
    // keeps uart_txd glitch-free.
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
